gtx_drp_arbiter: RTL and testbench
==================================

Name: gtx_drp_arbiter

Overview:
- Shares the single DRP port of one front-panel BERT GTX lane between two requesters.
- Port A is the management/register interface; port B is the eye-scan / RX tuning engine.
- Serialises transactions, arbitrates round-robin on contention, and times out hung accesses.
- One instance per lane in the BERT subsystem. Replaces the tied-off DRP inputs on the lane transceiver wrappers.

Parameters:
TIMEOUT_CYCLES, 1024, cycles in WAIT without drp_rdy before the access is aborted (min 2)

Ports:
clk_125mhz  in  1  system clock; also drives the GTX drpclk
rst  in  1  synchronous active-high reset
a_en  in  1  port A request strobe, 1 cycle
a_we  in  1  port A write (1) / read (0)
a_addr  in  9  port A DRP address
a_wdata  in  16  port A write data
a_ready  out  1  port A can accept a request
a_done  out  1  port A completion pulse
a_timeout  out  1  qualifies a_done: access timed out
a_rdata  out  16  port A read data
b_en, b_we, b_addr, b_wdata, b_ready, b_done, b_timeout, b_rdata  same as port A, for port B
drp_en  out  1  to GTX drpen
drp_we  out  1  to GTX drpwe
drp_addr  out  9  to GTX drpaddr
drp_di  out  16  to GTX drpdi
drp_do  in  16  from GTX drpdo
drp_rdy  in  1  from GTX drprdy
busy  out  1  FSM not IDLE

Behaviour:
Reset values:
- All outputs 0, except a_ready=1 and b_ready=1.
- Pending flags cleared; rdata registers 0.
- last_grant=B, so A wins the first contention.

Request capture (per port):
- x_en sampled while x_ready=1: latch we/addr/wdata and set pending_x.
- x_ready = !pending_x, registered; falls the cycle after the accepted strobe.
- x_en while x_ready=0 is silently dropped. The latched request is unchanged.

FSM states: IDLE, WAIT.
- IDLE, with any pending:
  - Grant A if only A is pending, B if only B is pending.
  - If both are pending, grant the port != last_grant, then update last_grant.
  - Next cycle: drp_en=1 for exactly one cycle, with drp_we/addr/di from the granted latch. Enter WAIT.
- WAIT:
  - drp_addr, drp_we and drp_di are held stable.
  - A cycle counter starts at 0 in the drp_en cycle and increments each cycle.
  - drp_rdy is ignored in the drp_en cycle itself.
- drp_rdy=1 in WAIT (cycle M):
  - On a read, x_rdata <= drp_do; on a write, x_rdata is unchanged.
  - x_done=1 and x_timeout=0 in cycle M+1.
  - pending_x is cleared, so x_ready=1 in M+1.
  - FSM returns to IDLE in M+1.
- Counter reaches TIMEOUT_CYCLES with no drp_rdy:
  - x_done=1 and x_timeout=1 for one cycle; x_rdata unchanged.
  - pending_x cleared; FSM returns to IDLE.
- drp_rdy in IDLE (late or stray) is ignored.

Latency:
- Uncontended, idle: x_en in cycle N, drp_en in cycle N+2.
- x_done is asserted 1 cycle after drp_rdy.

Throughput:
- At most one DRP transaction in flight.
- A new x_en in the x_done cycle is accepted.
- The other port's pending request is issued so that drp_en falls 2 cycles after done: IDLE decision in done cycle, drp_en the next.

Contention:
- Simultaneous a_en and b_en from idle: both latch.
- Grant order is A then B. A subsequent simultaneous pair after B was served goes A first again.

Timeout:
- Counter width is clog2(TIMEOUT_CYCLES+1).
- No saturation issue, because the counter is reset on every grant.

Reset mid-operation:
- Abandons the transaction, with no done pulse.
- drp_en drops immediately at the next edge.
- A late drp_rdy after reset is ignored.

busy is registered: 1 throughout WAIT and in the drp_en cycle.

Test Plan:
1. Single read: a_en, a_we=0, a_addr=9'h05E. Model returns drp_do=16'h1234 with drp_rdy 3 cycles after drp_en -> drp_en at N+2 with addr 05E and drp_we=0. a_done=1, a_timeout=0, a_rdata=16'h1234 one cycle after drp_rdy. a_ready low N+1 until done.
2. Single write: b_en, b_we=1, b_addr=9'h03D, b_wdata=16'hBEEF -> drp_en/drp_we=1 with di=BEEF. b_done pulse. b_rdata stays 0. a_* outputs untouched.
3. Contention: a_en and b_en in the same cycle (A read 0x010, B read 0x020) -> DRP order 0x010 then 0x020, exactly one drp_en each. a_done precedes b_done. Repeat the same pair -> A served first again.
4. Dropped strobe: a_en accepted (addr 0x011), then a second a_en (addr 0x099) while a_ready=0 -> only addr 0x011 is issued. Exactly one a_done.
5. Timeout: TIMEOUT_CYCLES=16, model never asserts drp_rdy -> a_done=1 and a_timeout=1 exactly 16 cycles after drp_en; FSM IDLE. A pending B request is issued next. A stray drp_rdy afterwards produces no done.
6. Reset mid-WAIT: assert rst for 1 cycle 2 cycles after drp_en -> no a_done. Ready outputs return to 1, busy=0, drp_en=0. A later drp_rdy is ignored. The next request completes normally.

Source files
------------

// File: rtl/gtx_drp_arbiter.sv
// Two-port DRP arbiter for one BERT GTX lane. Port A is the management
// interface, port B the eye-scan / RX tuning engine. One transaction is in
// flight at a time; contention is resolved round-robin and hung accesses are
// aborted after TIMEOUT_CYCLES without drp_rdy.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no access in flight; grant a pending port if any
// WAIT   | drp_en issued, waiting for drp_rdy or the timeout count
module gtx_drp_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_125mhz,
    input  logic        rst,
    input  logic        a_en,
    input  logic        a_we,
    input  logic [8:0]  a_addr,
    input  logic [15:0] a_wdata,
    output logic        a_ready,
    output logic        a_done,
    output logic        a_timeout,
    output logic [15:0] a_rdata,
    input  logic        b_en,
    input  logic        b_we,
    input  logic [8:0]  b_addr,
    input  logic [15:0] b_wdata,
    output logic        b_ready,
    output logic        b_done,
    output logic        b_timeout,
    output logic [15:0] b_rdata,
    output logic        drp_en,
    output logic        drp_we,
    output logic [8:0]  drp_addr,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    input  logic        drp_rdy,
    output logic        busy
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          pend_a, pend_b;
    logic          lat_a_we, lat_b_we;
    logic [8:0]    lat_a_addr, lat_b_addr;
    logic [15:0]   lat_a_wdata, lat_b_wdata;
    logic          grant_b;
    logic          last_grant_b;
    logic          issue, issue_b, fin_ok, fin_to;

    assign a_ready = ~pend_a;
    assign b_ready = ~pend_b;

    // State register, wait counter and round-robin history
    always_ff @(posedge clk_125mhz) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            grant_b      <= 1'b0;
            last_grant_b <= 1'b1;
            busy         <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == S_WAIT);
            if (issue) begin
                cnt          <= '0;
                grant_b      <= issue_b;
                last_grant_b <= issue_b;
            end else if (state == S_WAIT) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Next-state decision
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (pend_a || pend_b) state_nxt = S_WAIT;
            S_WAIT: if (fin_ok || fin_to) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Grant selection and completion qualifiers; drp_en high marks the
    // first WAIT cycle, in which drp_rdy is not trusted
    always_comb begin
        issue   = (state == S_IDLE) && (pend_a || pend_b);
        issue_b = pend_b && (!pend_a || !last_grant_b);
        fin_ok  = (state == S_WAIT) && !drp_en && drp_rdy;
        fin_to  = (state == S_WAIT) && !fin_ok && (cnt == CW'(TIMEOUT_CYCLES - 1));
    end

    // Request capture and pending flags per port
    always_ff @(posedge clk_125mhz) begin
        if (rst) begin
            pend_a      <= 1'b0;
            pend_b      <= 1'b0;
            lat_a_we    <= 1'b0;
            lat_a_addr  <= '0;
            lat_a_wdata <= '0;
            lat_b_we    <= 1'b0;
            lat_b_addr  <= '0;
            lat_b_wdata <= '0;
        end else begin
            if (a_en && !pend_a) begin
                pend_a      <= 1'b1;
                lat_a_we    <= a_we;
                lat_a_addr  <= a_addr;
                lat_a_wdata <= a_wdata;
            end else if ((fin_ok || fin_to) && !grant_b) begin
                pend_a <= 1'b0;
            end
            if (b_en && !pend_b) begin
                pend_b      <= 1'b1;
                lat_b_we    <= b_we;
                lat_b_addr  <= b_addr;
                lat_b_wdata <= b_wdata;
            end else if ((fin_ok || fin_to) && grant_b) begin
                pend_b <= 1'b0;
            end
        end
    end

    // DRP strobe and held address/data for the granted request
    always_ff @(posedge clk_125mhz) begin
        if (rst) begin
            drp_en   <= 1'b0;
            drp_we   <= 1'b0;
            drp_addr <= '0;
            drp_di   <= '0;
        end else begin
            drp_en <= issue;
            if (issue) begin
                drp_we   <= issue_b ? lat_b_we    : lat_a_we;
                drp_addr <= issue_b ? lat_b_addr  : lat_a_addr;
                drp_di   <= issue_b ? lat_b_wdata : lat_a_wdata;
            end
        end
    end

    // Completion pulses and read data return
    always_ff @(posedge clk_125mhz) begin
        if (rst) begin
            a_done    <= 1'b0;
            a_timeout <= 1'b0;
            a_rdata   <= '0;
            b_done    <= 1'b0;
            b_timeout <= 1'b0;
            b_rdata   <= '0;
        end else begin
            a_done    <= (fin_ok || fin_to) && !grant_b;
            a_timeout <= fin_to && !grant_b;
            b_done    <= (fin_ok || fin_to) && grant_b;
            b_timeout <= fin_to && grant_b;
            if (fin_ok && !drp_we && !grant_b) a_rdata <= drp_do;
            if (fin_ok && !drp_we && grant_b)  b_rdata <= drp_do;
        end
    end

endmodule

// File: tb/tb_gtx_drp_arbiter.sv
// Directed bench for gtx_drp_arbiter with a small DRP responder model.
module tb_gtx_drp_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_en = 1'b0, a_we = 1'b0, b_en = 1'b0, b_we = 1'b0;
    logic [8:0]  a_addr = '0, b_addr = '0;
    logic [15:0] a_wdata = '0, b_wdata = '0;
    logic        a_ready, a_done, a_timeout, b_ready, b_done, b_timeout;
    logic [15:0] a_rdata, b_rdata;
    logic        drp_en, drp_we, drp_rdy = 1'b0, busy;
    logic [8:0]  drp_addr;
    logic [15:0] drp_di, drp_do = '0;

    gtx_drp_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk_125mhz(clk), .rst(rst),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ready(a_ready), .a_done(a_done), .a_timeout(a_timeout), .a_rdata(a_rdata),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ready(b_ready), .b_done(b_done), .b_timeout(b_timeout), .b_rdata(b_rdata),
        .drp_en(drp_en), .drp_we(drp_we), .drp_addr(drp_addr), .drp_di(drp_di),
        .drp_do(drp_do), .drp_rdy(drp_rdy), .busy(busy)
    );

    always #4 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // responder controls: delay 0 means never answer
    int          resp_delay = 0;
    logic [15:0] resp_data  = '0;
    int          countdown  = -1;
    logic        stray_req  = 1'b0;

    // transaction log
    int          log_n = 0;
    logic [8:0]  log_addr [0:15];
    logic        log_we   [0:15];
    logic [15:0] log_di   [0:15];
    int          log_cyc  [0:15];
    logic        log_busy [0:15];
    int          a_done_cnt = 0, b_done_cnt = 0;
    int          a_done_cyc = 0, b_done_cyc = 0;
    logic        a_to_last = 1'b0, b_to_last = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // DRP responder: drp_rdy resp_delay cycles after drp_en
    always @(negedge clk) begin
        drp_rdy = 1'b0;
        if (stray_req) begin
            drp_rdy   = 1'b1;
            stray_req = 1'b0;
        end
        if (countdown > 0) begin
            countdown = countdown - 1;
            if (countdown == 0) begin
                drp_rdy   = 1'b1;
                drp_do    = resp_data;
                countdown = -1;
            end
        end
        if (drp_en && resp_delay > 0) countdown = resp_delay;
    end

    // monitor
    always @(negedge clk) begin
        if (drp_en && log_n < 16) begin
            log_addr[log_n] = drp_addr;
            log_we[log_n]   = drp_we;
            log_di[log_n]   = drp_di;
            log_cyc[log_n]  = cyc;
            log_busy[log_n] = busy;
            log_n = log_n + 1;
        end
        if (a_done) begin
            a_done_cnt = a_done_cnt + 1;
            a_done_cyc = cyc;
            a_to_last  = a_timeout;
        end
        if (b_done) begin
            b_done_cnt = b_done_cnt + 1;
            b_done_cyc = cyc;
            b_to_last  = b_timeout;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        @(negedge clk);
        log_n = 0;
        a_done_cnt = 0;
        b_done_cnt = 0;
    endtask

    // one-cycle request strobes; n returns the strobe cycle
    task automatic req(input logic do_a, input logic do_b, input logic we,
                       input logic [8:0] aa, input logic [8:0] ba,
                       input logic [15:0] wd, output int n);
        @(posedge clk); #1;
        n = cyc;
        a_en = do_a; a_we = we; a_addr = aa; a_wdata = wd;
        b_en = do_b; b_we = we; b_addr = ba; b_wdata = wd;
        @(posedge clk); #1;
        a_en = 1'b0; b_en = 1'b0;
    endtask

    task automatic wait_idle(input int max, input string tag);
        int ok = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (!busy && !drp_en && a_ready && b_ready) begin
                ok = 1;
                break;
            end
        end
        @(negedge clk);
        chk({tag, "_idle"}, ok, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got hang exp finish");
        $fatal(1, "watchdog");
    end

    int n;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_flags", {a_ready, b_ready, busy, drp_en, a_done, b_done, a_timeout, b_timeout},
            8'b1100_0000);
        chk("rst_rdata", {a_rdata, b_rdata}, 32'h0);

        // 1: single read on A
        resp_delay = 3; resp_data = 16'h1234;
        clear_log();
        req(1, 0, 0, 9'h05E, 9'h0, 16'h0, n);
        chk("t1_ready_low", a_ready, 0);
        wait_idle(100, "t1");
        chk("t1_n", log_n, 1);
        chk("t1_en_cyc", log_cyc[0], n + 2);
        chk("t1_addr_we", {log_addr[0], log_we[0]}, {9'h05E, 1'b0});
        chk("t1_busy", log_busy[0], 1);
        chk("t1_done_cyc", a_done_cyc, n + 6);
        chk("t1_done", {a_done_cnt[7:0], 7'b0, a_to_last}, {8'd1, 8'd0});
        chk("t1_rdata", a_rdata, 16'h1234);

        // 2: single write on B
        clear_log();
        req(0, 1, 1, 9'h0, 9'h03D, 16'hBEEF, n);
        wait_idle(100, "t2");
        chk("t2_n", log_n, 1);
        chk("t2_xact", {log_addr[0], log_we[0], log_di[0]}, {9'h03D, 1'b1, 16'hBEEF});
        chk("t2_done", {b_done_cnt[7:0], a_done_cnt[7:0]}, {8'd1, 8'd0});
        chk("t2_rdata", {b_rdata, a_rdata}, {16'h0, 16'h1234});

        // 3: contention, twice
        resp_data = 16'hA5A5;
        for (int r = 0; r < 2; r++) begin
            clear_log();
            req(1, 1, 0, 9'h010, 9'h020, 16'h0, n);
            wait_idle(100, "t3");
            chk("t3_n", log_n, 2);
            chk("t3_order", {log_addr[0], log_addr[1]}, {9'h010, 9'h020});
            chk("t3_gap", log_cyc[1], log_cyc[0] + 5);
            chk("t3_done_order", (a_done_cyc < b_done_cyc), 1);
            chk("t3_done_cnt", {a_done_cnt[7:0], b_done_cnt[7:0]}, {8'd1, 8'd1});
            chk("t3_rdata", b_rdata, 16'hA5A5);
        end

        // 4: dropped strobe while a_ready low
        clear_log();
        req(1, 0, 0, 9'h011, 9'h0, 16'h0, n);
        a_en = 1'b1; a_addr = 9'h099;
        @(posedge clk); #1 a_en = 1'b0;
        wait_idle(100, "t4");
        chk("t4_n", log_n, 1);
        chk("t4_addr", log_addr[0], 9'h011);
        chk("t4_done_cnt", a_done_cnt, 1);

        // 5: timeout on A with B queued behind it
        resp_delay = 0;
        clear_log();
        req(1, 0, 0, 9'h077, 9'h0, 16'h0, n);
        req(0, 1, 0, 9'h0, 9'h078, 16'h0, n);
        wait_idle(200, "t5");
        chk("t5_n", log_n, 2);
        chk("t5_a_to_cyc", a_done_cyc, log_cyc[0] + 16);
        chk("t5_a_to", {a_done_cnt[7:0], 7'b0, a_to_last}, {8'd1, 8'd1});
        chk("t5_b_issue", {log_addr[1], 23'd0}, {9'h078, 23'd0});
        chk("t5_b_en_cyc", log_cyc[1], a_done_cyc + 1);
        chk("t5_b_to", {b_done_cnt[7:0], 7'b0, b_to_last}, {8'd1, 8'd1});
        chk("t5_rdata", a_rdata, 16'hA5A5);
        stray_req = 1'b1;
        repeat (5) @(negedge clk);
        chk("t5_stray", {a_done_cnt[7:0], b_done_cnt[7:0], 7'b0, busy}, {8'd1, 8'd1, 8'd0});

        // 6: reset two cycles after drp_en
        clear_log();
        req(1, 0, 0, 9'h050, 9'h0, 16'h0, n);
        for (int i = 0; i < 20 && log_n == 0; i++) @(negedge clk);
        chk("t6_issued", log_n, 1);
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("t6_after_rst", {a_ready, b_ready, busy, drp_en}, 4'b1100);
        stray_req = 1'b1;
        repeat (5) @(negedge clk);
        chk("t6_no_done", a_done_cnt, 0);
        chk("t6_rdata_clr", a_rdata, 16'h0);
        resp_delay = 2; resp_data = 16'h5151;
        clear_log();
        req(1, 0, 0, 9'h051, 9'h0, 16'h0, n);
        wait_idle(100, "t6b");
        chk("t6_next_addr", log_addr[0], 9'h051);
        chk("t6_next_done", {a_done_cnt[7:0], 7'b0, a_to_last}, {8'd1, 8'd0});
        chk("t6_next_rdata", a_rdata, 16'h5151);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
